// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, counter width, decoder FSM encoding
// and the saturating counter helper.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int H_ACTIVE = 640;
  localparam int H_SYNC   = 96;
  localparam int V_TOTAL  = 525;
  localparam int V_ACTIVE = 480;
  localparam int V_SYNC   = 2;

  localparam int CW = 10;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/vga_bbox.sv
// Per-frame bounding box of ball pixels; publishes the box centre at each
// frame boundary and forgets the partial box when told to clear.
module vga_bbox
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_vld,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          frame_done,
  input  logic          clear,
  output logic          found,
  output logic [CW-1:0] cx,
  output logic [CW-1:0] cy
);

  logic [CW-1:0] minx_q, maxx_q, miny_q, maxy_q;
  logic [CW-1:0] minx_d, maxx_d, miny_d, maxy_d;
  logic          seen_q, seen_d;
  logic          found_q;
  logic [CW-1:0] cx_q, cy_q;
  logic [CW:0]   sumx, sumy;

  // Fold the current pixel in before publishing, so a pixel on the boundary
  // cycle is not lost.
  always_comb begin
    minx_d = (pix_vld && (x < minx_q)) ? x : minx_q;
    maxx_d = (pix_vld && (x > maxx_q)) ? x : maxx_q;
    miny_d = (pix_vld && (y < miny_q)) ? y : miny_q;
    maxy_d = (pix_vld && (y > maxy_q)) ? y : maxy_q;
    seen_d = seen_q | pix_vld;
    sumx   = {1'b0, minx_d} + {1'b0, maxx_d};
    sumy   = {1'b0, miny_d} + {1'b0, maxy_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minx_q  <= CNT_MAX;
      maxx_q  <= '0;
      miny_q  <= CNT_MAX;
      maxy_q  <= '0;
      seen_q  <= 1'b0;
      found_q <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else if (clear || frame_done) begin
      minx_q <= CNT_MAX;
      maxx_q <= '0;
      miny_q <= CNT_MAX;
      maxy_q <= '0;
      seen_q <= 1'b0;
      if (clear) begin
        found_q <= 1'b0;
      end else begin
        found_q <= seen_d;
        if (seen_d) begin
          cx_q <= sumx[CW:1];
          cy_q <= sumy[CW:1];
        end
      end
    end else begin
      minx_q <= minx_d;
      maxx_q <= maxx_d;
      miny_q <= miny_d;
      maxy_q <= maxy_d;
      seen_q <= seen_d;
    end
  end

  assign found = found_q;
  assign cx    = cx_q;
  assign cy    = cy_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and timing lock from a VGA sync/blank stream and
// locates a pure-blue ball in each locked frame.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs_n,
  input  logic          vs_n,
  input  logic          blank_n,
  input  logic          r,
  input  logic          g,
  input  logic          b,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          locked,
  output logic          frame_done,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic          ball_found,
  output logic [CW-1:0] ball_x,
  output logic [CW-1:0] ball_y,
  output logic          err_timing
);

  localparam logic [CW-1:0] H_TOT_C = CW'(H_TOT);
  localparam logic [CW-1:0] V_TOT_C = CW'(V_TOT);

  logic          hs_q, vs_q, blank_q, r_q, g_q, b_q;
  logic          hs_fall, vs_fall, blank_rise, blank_fall;
  logic [CW-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [CW-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic [CW-1:0] htot_q, htot_d, vtot_q, vtot_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  state_t        state_q, state_d;
  logic          meas_q, meas_d;
  logic          err_q, err_d;
  logic          fdone_q, fdone_d;
  logic          totals_ok, h_bad, v_bad, lock_loss, ball_pix;

  assign hs_fall    = hs_q & ~hs_n;
  assign vs_fall    = vs_q & ~vs_n;
  assign blank_rise = ~blank_q & blank_n;
  assign blank_fall = blank_q & ~blank_n;

  always_comb begin
    hcnt_d = hs_fall ? '0 : sat_inc(hcnt_q);
    htot_d = hs_fall ? sat_inc(hcnt_q) : htot_q;

    // A vsync edge wins over a coincident hsync edge; that hsync edge still
    // closes the last line of the frame, so it is counted into v_total.
    if (vs_fall)      lcnt_d = '0;
    else if (hs_fall) lcnt_d = sat_inc(lcnt_q);
    else              lcnt_d = lcnt_q;
    if (vs_fall)      vtot_d = hs_fall ? sat_inc(lcnt_q) : lcnt_q;
    else              vtot_d = vtot_q;

    if (blank_rise)   xcnt_d = '0;
    else if (blank_n) xcnt_d = sat_inc(xcnt_q);
    else              xcnt_d = xcnt_q;

    if (vs_fall)         ycnt_d = '0;
    else if (blank_fall) ycnt_d = sat_inc(ycnt_q);
    else                 ycnt_d = ycnt_q;
  end

  assign totals_ok = (htot_d == H_TOT_C) && (vtot_d == V_TOT_C);
  assign h_bad     = hs_fall && (htot_d != H_TOT_C);
  assign v_bad     = vs_fall && (vtot_d != V_TOT_C);

  always_comb begin
    state_d = state_q;
    meas_d  = meas_q;
    err_d   = err_q;
    fdone_d = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_MEASURE;
          meas_d  = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (!totals_ok)  state_d = ST_SEARCH;
          else if (meas_q) state_d = ST_LOCKED;
          else             meas_d  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (h_bad || v_bad) begin
          err_d   = 1'b1;
          state_d = ST_SEARCH;
        end else if (vs_fall) begin
          fdone_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  assign lock_loss = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);

  // Published coordinates only move on cycles that will be presented as active.
  assign x_d = (blank_n && (state_d == ST_LOCKED)) ? xcnt_d : x_q;
  assign y_d = (blank_n && (state_d == ST_LOCKED)) ? ycnt_d : y_q;

  // Input register stage and all timing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      xcnt_q  <= '0;
      ycnt_q  <= '0;
      htot_q  <= '0;
      vtot_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      state_q <= ST_SEARCH;
      meas_q  <= 1'b0;
      err_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      blank_q <= blank_n;
      r_q     <= r;
      g_q     <= g;
      b_q     <= b;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      xcnt_q  <= xcnt_d;
      ycnt_q  <= ycnt_d;
      htot_q  <= htot_d;
      vtot_q  <= vtot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      state_q <= state_d;
      meas_q  <= meas_d;
      err_q   <= err_d;
      fdone_q <= fdone_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign active     = blank_q & locked;
  assign ball_pix   = active & b_q & ~r_q & ~g_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = fdone_q;
  assign h_total    = htot_q;
  assign v_total    = vtot_q;
  assign err_timing = err_q;

  // The box centre is published on the same edge that raises frame_done.
  vga_bbox u_bbox (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_vld   (ball_pix),
    .x         (x_q),
    .y         (y_q),
    .frame_done(fdone_d),
    .clear     (lock_loss),
    .found     (ball_found),
    .cx        (ball_x),
    .cy        (ball_y)
  );

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Ports SHALL be:
- clk  in  1  pixel clock, 25 MHz; the same domain as VGA_CLK
- rst_n  in  1  asynchronous, active-low reset
- hs_n  in  1  horizontal sync, active low
- vs_n  in  1  vertical sync, active low
- blank_n  in  1  high during the visible area
- r, g, b  in  1 each  colour MSBs
- x, y  out  10 each  recovered coordinate of the current active pixel
- active  out  1  x and y are valid
- locked  out  1  timing is locked
- frame_done  out  1  one-cycle pulse at each vs_n falling edge while locked
- h_total, v_total  out  10 each  last measured line length (clocks) and frame length (lines)
- ball_found, ball_x, ball_y  out  1, 10, 10  ball bounding-box centre from the last frame
- err_timing  out  1  sticky timing-error flag; cleared only by reset
REQ-003 Expected timing SHALL be: H 800 total, 640 active, 96 sync; V 525 total, 480 active, 2 sync.

Function
REQ-004 All inputs SHALL be registered once, so the outputs lag the pixel inputs by 1 clk.
REQ-005 Edges on hs_n and vs_n SHALL be detected against the registered copy of each signal.
REQ-006 The hclk counter SHALL reset to 0 on each hs_n falling edge; h_total SHALL latch the count plus 1 at that edge.
REQ-007 The line counter SHALL increment on each hs_n falling edge and reset on each vs_n falling edge; v_total SHALL latch the line count at that edge.
REQ-008 The x counter SHALL clear when blank_n rises and increment on each cycle while blank_n is high.
REQ-009 The y counter SHALL increment on each blank_n falling edge and clear on each vs_n falling edge.
REQ-010 Both counters SHALL saturate at 1023.
REQ-011 active SHALL equal registered blank_n AND locked.
REQ-012 While active is 0, x and y SHALL hold their last values.
REQ-013 The FSM SHALL have three states:
- SEARCH: wait for a vs_n falling edge, then go to MEASURE.
- MEASURE: at each vs_n falling edge, compare the totals to 800/525. Two consecutive matching frames go to LOCKED; any mismatch returns to SEARCH.
- LOCKED: any mismatch of h_total at an hs edge, or of v_total at a vs edge, sets err_timing, clears locked in the next cycle, and returns to SEARCH.
REQ-014 locked SHALL be 1 only in LOCKED.
REQ-015 A ball pixel SHALL be a cycle with b=1, r=0, g=0 and active=1.
REQ-016 Per frame, the block SHALL track min/max x and min/max y of ball pixels.
REQ-017 At frame_done:
- ball_x SHALL be (minx+maxx)>>1 and ball_y SHALL be (miny+maxy)>>1, computed with an 11-bit sum.
- ball_found SHALL be 1 if any ball pixel was seen.
- The trackers SHALL then reinitialise to min=1023 and max=0.
- If no ball pixel was seen, ball_x and ball_y SHALL hold their previous values.
REQ-018 If hs_n and vs_n fall in the same cycle, the line reset SHALL take priority over the line increment.
REQ-019 Loss of lock SHALL clear ball_found and discard the partial-frame bounding box.

Reset
REQ-020 Reset SHALL be asynchronous on rst_n low and SHALL set these values:
- FSM to SEARCH
- all counters to 0
- x, y, h_total, v_total, ball_x, ball_y to 0
- locked, active, frame_done, ball_found, err_timing to 0
- bounding-box trackers to min=1023, max=0
REQ-021 Release of rst_n mid-frame SHALL resume in SEARCH, with lock re-acquired after 2 full frames.

Structure
REQ-022 The timing constants (800, 640, 96, 525, 480, 2) and the FSM state encoding SHALL reside in the shared package vga_pkg.
REQ-023 The bounding-box min/max tracking SHALL be one sub-module, vga_bbox: inputs clk, rst_n, pixel valid, x, y, frame_done, clear; outputs found, cx, cy.

Verification
REQ-024 Feed an ideal 800x525 stream from reset -> locked=1 one clk after the third vs_n falling edge; h_total=800; v_total=525.
REQ-025 Drive an 8x8 pure-blue block at x 100..107, y 200..207 -> at the next frame_done, ball_found=1, ball_x=103, ball_y=203.
REQ-026 Shorten one line to 799 clocks while locked -> err_timing=1, locked=0, FSM in SEARCH; relock after 2 clean frames.
REQ-027 Drive a frame with no blue pixels -> ball_found=0 at frame_done, and ball_x/ball_y retain their prior values.
REQ-028 Assert rst_n low at line 240 -> all outputs 0 immediately; after release, locked=1 only after 3 vs_n falling edges.
REQ-029 Drive a white pixel (r=g=b=1) inside the ball area -> it is excluded from the box; the centre is unchanged from the pure-blue result.
